tristate_bus_arbiter: RTL
=========================

TRISTATE_BUS_ARBITER -- requirements
Module: tristate_bus_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 4: number of bus drivers, at least 2.
REQ-002 Parameter DATA_W, default 8: bus width in bits.
REQ-003 Parameter MAX_BURST, default 4: maximum consecutive GRANT cycles per tenure, at least 1.
REQ-004 Parameter TURNAROUND, default 1: all-Z cycles between tenures, at least 1.
REQ-005 Port clk, input, 1: sole clock, rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 Port req, input, NUM_MASTERS: per-master bus request, level-sensitive.
REQ-008 Port wr_data, input, NUM_MASTERS*DATA_W: master i's data in slice [i*DATA_W +: DATA_W].
REQ-009 Port ext_busy, input, 1: an external agent is driving bus; no internal grant is allowed.
REQ-010 Port bus, inout tri, DATA_W: shared bus, driven only by the granted master, else Z.
REQ-011 Port grant, output, NUM_MASTERS: registered one-hot-or-zero grant.
REQ-012 Port owner, output, $clog2(NUM_MASTERS): index of the current or last owner.
REQ-013 Port bus_busy, output, 1: high while any internal grant is active.
REQ-014 Port bus_q, output, DATA_W: bus sampled every rising edge, for listeners.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, GRANT and TURN.
REQ-016 IDLE SHALL go to GRANT at the next edge when any req is high and ext_busy is low.
REQ-017 On entry to GRANT, owner SHALL be the first requester at or after rr_ptr, searching upward with wrap from NUM_MASTERS-1 to 0.
REQ-018 In GRANT, grant[owner] SHALL be 1, all other grant bits 0, and bus SHALL equal wr_data slice [owner].
REQ-019 A beat counter SHALL start at 0 on GRANT entry and increment each GRANT cycle.
REQ-020 GRANT SHALL go to TURN at the next edge if req[owner] is low, beat equals MAX_BURST-1, or ext_busy is high.
REQ-021 On leaving GRANT, rr_ptr SHALL become (owner+1) mod NUM_MASTERS.
REQ-022 TURN SHALL last exactly TURNAROUND cycles with grant all 0 and bus all Z.
REQ-023 When TURN ends, the FSM SHALL go to GRANT if any req is high and ext_busy is low, else to IDLE.
REQ-024 At most one internal driver SHALL be enabled in any cycle, with no exceptions.
REQ-025 bus_busy SHALL equal (state == GRANT).
REQ-026 A req edge during TURN SHALL NOT shorten TURN.
REQ-027 ext_busy high in IDLE or at the end of TURN SHALL hold or move the FSM to IDLE.
REQ-028 If only the previous owner requests after TURN, it SHALL be re-granted.
REQ-029 When NUM_MASTERS is not a power of two, rr_ptr wrap SHALL skip out-of-range indices.

Reset
REQ-030 rst_n low SHALL immediately force state=IDLE, grant=0, bus=Z, owner=0, rr_ptr=0, beat=0, TURN counter=0, bus_q=0, bus_busy=0.
REQ-031 Assertion of rst_n mid-GRANT SHALL release bus to Z without waiting for a clock edge.
REQ-032 After rst_n deasserts, the first grant SHALL occur no earlier than the second rising edge.

Structure
REQ-033 The state enum and the rr_pick function prototype SHALL live in package bus_arb_pkg.
REQ-034 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs: req, rr_ptr; outputs: valid, index).
REQ-035 Per-master tri-state drivers SHALL be a generate loop, one conditional-Z assign per master.

Verification (NUM_MASTERS=4, DATA_W=8, MAX_BURST=4, TURNAROUND=1)
REQ-036 Single requester: req=0010 held 10 cycles with wr_data[1]=8'hA5 -> grant=0010 and bus=A5 for 4 cycles, 1 Z cycle, then re-grant; bus_q tracks with 1-cycle lag.
REQ-037 Contention: req=1111 held, rr_ptr=0 -> owners 0,1,2,3,0 in order, each 4 beats, one all-Z cycle between tenures, grant never multi-hot.
REQ-038 Early release: master 2 drops req after 2 beats -> TURN on the next edge, rr_ptr=3.
REQ-039 External preemption: ext_busy=1 in the second beat of master 0 -> grant=0000 on the next edge, bus=Z, no new grant until ext_busy=0.
REQ-040 Reset mid-burst: rst_n=0 between edges during GRANT -> bus=Z and grant=0 immediately; after release, the first grant goes to the lowest requester.
REQ-041 Idle: req=0000 -> bus=ZZZZZZZZ, bus_busy=0 indefinitely.

Source files
------------

// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared types for the tri-state bus arbiter: FSM states and the
// round-robin search used by rr_pick.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TURN
  } arb_state_t;

  localparam int unsigned MAX_MASTERS = 64;
  localparam int unsigned MAX_IDX_W   = 6;

  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] index;
  } pick_t;

  // First set bit at or above ptr, wrapping at n (indices >= n never considered).
  function automatic pick_t rr_pick_fn(input logic [MAX_MASTERS-1:0] req,
                                       input int unsigned n,
                                       input int unsigned ptr);
    pick_t       r;
    int unsigned idx;
    r = '0;
    for (int unsigned k = 0; k < MAX_MASTERS; k++) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (!r.valid && req[idx[MAX_IDX_W-1:0]]) begin
          r.valid = 1'b1;
          r.index = idx[MAX_IDX_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned IDX_W       = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       rr_ptr,
  output logic                   valid,
  output logic [IDX_W-1:0]       index
);

  logic [MAX_MASTERS-1:0] req_ext;
  pick_t                  p;

  always_comb begin
    req_ext                    = '0;
    req_ext[NUM_MASTERS-1:0]   = req;
    p     = rr_pick_fn(req_ext, NUM_MASTERS, 32'(rr_ptr));
    valid = p.valid;
    index = IDX_W'(p.index);
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter for a shared tri-state bus with bounded bursts,
// all-Z turnaround between tenures and external-agent preemption.
module tristate_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned MAX_BURST   = 4,
  parameter int unsigned TURNAROUND  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_MASTERS-1:0]        req,
  input  logic [NUM_MASTERS*DATA_W-1:0] wr_data,
  input  logic                          ext_busy,
  inout  tri   [DATA_W-1:0]             bus,
  output logic [NUM_MASTERS-1:0]        grant,
  output logic [$clog2(NUM_MASTERS)-1:0] owner,
  output logic                          bus_busy,
  output logic [DATA_W-1:0]             bus_q
);

  localparam int unsigned OW = $clog2(NUM_MASTERS);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam int unsigned TW = $clog2(TURNAROUND + 1);

  arb_state_t             state, state_n;
  logic [OW-1:0]          rr_ptr, rr_ptr_n, owner_n;
  logic [BW-1:0]          beat, beat_n;
  logic [TW-1:0]          turn_cnt, turn_n;
  logic [NUM_MASTERS-1:0] grant_n;
  logic                   started;
  logic                   pick_valid;
  logic [OW-1:0]          pick_idx;

  rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (OW)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .index  (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat     <= '0;
      turn_cnt <= '0;
      grant    <= '0;
      started  <= 1'b0;
      bus_q    <= '0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      rr_ptr   <= rr_ptr_n;
      beat     <= beat_n;
      turn_cnt <= turn_n;
      grant    <= grant_n;
      started  <= 1'b1;
      bus_q    <= bus;
    end
  end

  // started blocks a grant on the first edge after reset release.
  always_comb begin
    state_n  = state;
    owner_n  = owner;
    rr_ptr_n = rr_ptr;
    beat_n   = beat;
    turn_n   = turn_cnt;
    grant_n  = '0;
    unique case (state)
      IDLE: begin
        if (started && pick_valid && !ext_busy) begin
          state_n          = GRANT;
          owner_n          = pick_idx;
          beat_n           = '0;
          grant_n[pick_idx] = 1'b1;
        end
      end
      GRANT: begin
        if (!req[owner] || beat == BW'(MAX_BURST - 1) || ext_busy) begin
          state_n  = TURN;
          turn_n   = '0;
          rr_ptr_n = (owner == OW'(NUM_MASTERS - 1)) ? '0 : owner + 1'b1;
        end else begin
          beat_n         = beat + 1'b1;
          grant_n[owner] = 1'b1;
        end
      end
      TURN: begin
        if (turn_cnt == TW'(TURNAROUND - 1)) begin
          turn_n = '0;
          if (pick_valid && !ext_busy) begin
            state_n           = GRANT;
            owner_n           = pick_idx;
            beat_n            = '0;
            grant_n[pick_idx] = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          turn_n = turn_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus_busy = (state == GRANT);

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_drv
    assign bus = grant[i] ? wr_data[i*DATA_W +: DATA_W] : 'z;
  end

endmodule
